imem_loader: RTL

//  Byte-stream program loader: the write side of the instruction memory.

---
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader that writes into the instruction memory.
// Frames are SYNC, LEN, LEN little-endian word pairs, then an XOR checksum of the data bytes.
// The CPU is held in reset from an accepted SYNC until the frame ends, errors, or is aborted.
module imem_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StLo,
    StHi,
    StChk,
    StDone,
    StErr
  } state_t;

  localparam logic [ADDR_W:0]   CntOne = 1;
  localparam logic [ADDR_W-1:0] IdxOne = 1;
  localparam logic [7:0]        MaxLen = 8'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          lo_q, lo_d;
  logic [7:0]          chk_q, chk_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                error_q, error_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                accept;

  // Ready whenever a byte-consuming state is active and no abort is pending.
  always_comb begin
    in_ready = 1'b0;
    if (!abort) begin
      unique case (state_q)
        StIdle, StLen, StLo, StHi, StChk: in_ready = 1'b1;
        default:                          in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state and datapath updates; mem_we is a one-cycle strobe registered from the hi byte.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    error_d     = error_q;
    word_cnt_d  = word_cnt_q;

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      error_d    = 1'b1;
      cpu_hold_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && (in_data == SYNC)) begin
            state_d    = StLen;
            error_d    = 1'b0;
            word_cnt_d = '0;
            chk_d      = '0;
            idx_d      = '0;
            cpu_hold_d = 1'b1;
          end
        end
        StLen: begin
          if (accept) begin
            if ((in_data != 8'd0) && (in_data <= MaxLen)) begin
              len_d   = in_data[ADDR_W:0];
              state_d = StLo;
            end else begin
              state_d    = StErr;
              error_d    = 1'b1;
              cpu_hold_d = 1'b0;
            end
          end
        end
        StLo: begin
          if (accept) begin
            lo_d    = in_data;
            chk_d   = chk_q ^ in_data;
            state_d = StHi;
          end
        end
        StHi: begin
          if (accept) begin
            chk_d       = chk_q ^ in_data;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = {in_data, lo_q};
            word_cnt_d  = word_cnt_q + CntOne;
            // Last word goes to CHK without bumping the index, so it never wraps.
            if ({1'b0, idx_q} == (len_q - CntOne)) begin
              state_d = StChk;
            end else begin
              idx_d   = idx_q + IdxOne;
              state_d = StLo;
            end
          end
        end
        StChk: begin
          if (accept) begin
            cpu_hold_d = 1'b0;
            if (in_data == chk_q) begin
              state_d = StDone;
            end else begin
              state_d = StErr;
              error_d = 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        StErr:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      error_q     <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      error_q     <= error_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign error     = error_q;
  assign word_cnt  = word_cnt_q;
  assign done      = (state_q == StDone);

endmodule
